mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Execute-stage sequencer for the shared 32x32 multiplier, which samples `start` and pulses `ready` one cycle later.
- Accepts MUL.W / MULH.W / MULH.WU requests from EX and drives the multiplier start/operand/sign lines.
- Stalls the pipeline until the result is delivered, then returns the selected 32-bit half.
- A one-entry operand cache returns repeated operand pairs (e.g. MULH.W followed by MUL.W) without re-issuing to the multiplier.

Parameters:
- CACHE_EN, 1: 1 enables the operand/result cache; 0 makes every request a miss.
- WAIT_LIMIT, 15: maximum cycles in WAIT before the watchdog fires.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; aborts the current operation
- req_valid_i  in  1  EX holds a multiply; held stable with operands while stall_o=1
- req_op_i  in  2  00 MUL.W (low word), 01 MULH.W (signed high), 10 MULH.WU (unsigned high), 11 treated as 00
- src1_i  in  32  operand A
- src2_i  in  32  operand B
- ex_allowin_i  in  1  downstream accepts the result
- stall_o  out  1  hold EX stage
- res_valid_o  out  1  res_o valid
- res_o  out  32  selected result word
- mul_start_o  out  1  start pulse to multiplier
- mul_op1_o  out  32  latched operand A
- mul_op2_o  out  32  latched operand B
- mul_signed_o  out  1  signed multiply select; held stable from START through capture
- mul_flush_o  out  1  combinational copy of flush_i
- mul_ready_i  in  1  multiplier done pulse
- mul_result_i  in  64  multiplier product; valid while mul_ready_i=1
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cache invalid.
  - Latched operands and the result register are cleared; all outputs are 0.
- States:
  - IDLE:
    - req_valid_i & !flush_i latches src1/src2/op; signed = (op!=10). MUL.W issues signed, since its low word is sign-independent.
    - Hit: go to DONE.
    - Miss: go to START.
  - START:
    - mul_start_o=1 for exactly this cycle; go to WAIT.
  - WAIT:
    - mul_start_o=0; the multiplier ignores start while ready=1 and none is ever driven then.
    - On mul_ready_i: capture the full 64-bit product into the cache, set tag={op1,op2,signed}, set valid, go to DONE.
    - Wait counter increments each cycle. At WAIT_LIMIT without ready: err_o<=1 (sticky until reset), state->IDLE, no result, cache untouched.
  - DONE:
    - res_valid_o=1; res_o selected from the cache data.
    - ex_allowin_i=1: go to IDLE.
    - ex_allowin_i=0: hold res_valid_o and res_o unchanged.
- Hit rule:
  - Requires CACHE_EN & valid & op1/op2 equal to the tag.
  - Plus one of: request is MUL.W (either signedness matches), or the signed bit equals the tag signedness.
- Result select: op 00/11 gives data[31:0]; op 01/10 gives data[63:32].
- stall_o: 1 in IDLE when req_valid_i & !flush_i; 1 in START and WAIT; 0 in DONE and otherwise. New requests are considered only in IDLE.
- Latency from the accept cycle T:
  - Miss: START at T+1, mul_ready_i at T+2, DONE at T+3.
  - Hit: DONE at T+1.
- Flush:
  - In any state, flush_i=1 forces IDLE next cycle; mul_flush_o=1 in the same cycle.
  - Any pending or held result is dropped; res_valid_o=0 next cycle.
  - The cache is updated only on capture, so a flush during WAIT leaves the previous entry intact.
  - Flush has priority over mul_ready_i and ex_allowin_i in the same cycle.
- The cache is not cleared by flush: it holds a pure function of its tag.

Test Plan:
- **Miss path:** MUL.W, src1=0xFFFFFFFF, src2=0x00000002, cache empty.
  - mul_start_o=1 at T+1, mul_signed_o=1.
  - res_valid_o=1 at T+3 with res_o=0xFFFFFFFE; stall_o=1 for T..T+2.
- **Hit / signedness:** MULH.W, same operands, immediately after.
  - Hit: no mul_start_o, res_o=0xFFFFFFFF at T+1.
  - Then MULH.WU, same operands: miss, res_o=0x00000001 at T+3.
- **Backpressure:** ex_allowin_i=0 for 4 cycles in DONE.
  - res_valid_o and res_o held constant, no start pulse.
  - IDLE the cycle after ex_allowin_i=1.
- **Flush in WAIT:** flush_i=1 in the cycle mul_ready_i=1.
  - mul_flush_o=1 that cycle; IDLE next cycle, no res_valid_o.
  - Re-issuing the prior cached request still hits with the old data.
- **Async reset in WAIT:** rst_n=0 mid-WAIT.
  - All outputs 0 without waiting for a clk edge.
  - After release, an identical request misses (mul_start_o pulses).
- **Watchdog:** WAIT_LIMIT=4, mul_ready_i tied 0.
  - err_o=1 after 4 WAIT cycles, state returns to IDLE.
  - err_o stays 1 across later successful operations.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Bus between the execute-stage multiply sequencer (master) and the shared
// 32x32 multiplier (slave); names follow the sequencer's point of view.
interface mul_ctrl_if;
    logic        mul_start_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic        mul_signed_o;
    logic        mul_flush_o;
    logic        mul_ready_i;
    logic [63:0] mul_result_i;

    modport master (
        output mul_start_o, mul_op1_o, mul_op2_o, mul_signed_o, mul_flush_o,
        input  mul_ready_i, mul_result_i
    );

    modport slave (
        input  mul_start_o, mul_op1_o, mul_op2_o, mul_signed_o, mul_flush_o,
        output mul_ready_i, mul_result_i
    );
endinterface

// File: rtl/mul_ctrl.sv
// Execute-stage multiply sequencer: issues MUL.W/MULH.W/MULH.WU to the shared
// multiplier, stalls EX until the product returns, and caches the last product.
module mul_ctrl #(
    parameter bit CACHE_EN   = 1'b1,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              req_valid_i,
    input  logic [1:0]        req_op_i,
    input  logic [31:0]       src1_i,
    input  logic [31:0]       src2_i,
    input  logic              ex_allowin_i,
    output logic              stall_o,
    output logic              res_valid_o,
    output logic [31:0]       res_o,
    output logic              err_o,
    mul_ctrl_if.master        mul
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [1:0]      op_q, op_d;
    logic            isSigned_q, isSigned_d;
    logic            cacheValid_q, cacheValid_d;
    logic [63:0]     cacheData_q, cacheData_d;
    logic [31:0]     tagOp1_q, tagOp1_d;
    logic [31:0]     tagOp2_q, tagOp2_d;
    logic            tagSigned_q, tagSigned_d;
    logic [CW-1:0]   waitCnt_q, waitCnt_d;
    logic            err_q, err_d;

    logic            reqSigned;
    logic            reqIsLow;
    logic            reqHit;
    logic [31:0]     resWord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op1_q        <= '0;
            op2_q        <= '0;
            op_q         <= '0;
            isSigned_q   <= 1'b0;
            cacheValid_q <= 1'b0;
            cacheData_q  <= '0;
            tagOp1_q     <= '0;
            tagOp2_q     <= '0;
            tagSigned_q  <= 1'b0;
            waitCnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op_q         <= op_d;
            isSigned_q   <= isSigned_d;
            cacheValid_q <= cacheValid_d;
            cacheData_q  <= cacheData_d;
            tagOp1_q     <= tagOp1_d;
            tagOp2_q     <= tagOp2_d;
            tagSigned_q  <= tagSigned_d;
            waitCnt_q    <= waitCnt_d;
            err_q        <= err_d;
        end
    end

    // The low product word is sign-independent, so MUL.W hits on either signedness.
    assign reqSigned = (req_op_i != 2'b10);
    assign reqIsLow  = (req_op_i == 2'b00) || (req_op_i == 2'b11);
    assign reqHit    = CACHE_EN && cacheValid_q &&
                       (src1_i == tagOp1_q) && (src2_i == tagOp2_q) &&
                       (reqIsLow || (reqSigned == tagSigned_q));
    assign resWord   = (op_q[0] ^ op_q[1]) ? cacheData_q[63:32] : cacheData_q[31:0];

    assign err_o            = err_q;
    assign mul.mul_op1_o    = op1_q;
    assign mul.mul_op2_o    = op2_q;
    assign mul.mul_signed_o = isSigned_q;
    assign mul.mul_flush_o  = flush_i;

    always_comb begin
        state_d         = state_q;
        op1_d           = op1_q;
        op2_d           = op2_q;
        op_d            = op_q;
        isSigned_d      = isSigned_q;
        cacheValid_d    = cacheValid_q;
        cacheData_d     = cacheData_q;
        tagOp1_d        = tagOp1_q;
        tagOp2_d        = tagOp2_q;
        tagSigned_d     = tagSigned_q;
        waitCnt_d       = waitCnt_q;
        err_d           = err_q;
        stall_o         = 1'b0;
        res_valid_o     = 1'b0;
        res_o           = '0;
        mul.mul_start_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    stall_o    = 1'b1;
                    op1_d      = src1_i;
                    op2_d      = src2_i;
                    op_d       = req_op_i;
                    isSigned_d = reqSigned;
                    state_d    = reqHit ? S_DONE : S_START;
                end
            end
            S_START: begin
                stall_o         = 1'b1;
                mul.mul_start_o = 1'b1;
                waitCnt_d       = '0;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                // Flush wins over a same-cycle ready, leaving the cache untouched.
                if (!flush_i) begin
                    if (mul.mul_ready_i) begin
                        cacheData_d  = mul.mul_result_i;
                        tagOp1_d     = op1_q;
                        tagOp2_d     = op2_q;
                        tagSigned_d  = isSigned_q;
                        cacheValid_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (waitCnt_q == CW'(WAIT_LIMIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        waitCnt_d = waitCnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                res_valid_o = 1'b1;
                res_o       = resWord;
                if (ex_allowin_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: miss/hit paths, backpressure, flush, async reset
// and watchdog, with a one-cycle-latency multiplier model on the bus.
module tb_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        reqValid;
    logic [1:0]  reqOp;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        exAllowin;
    logic        stall;
    logic        resValid;
    logic [31:0] res;
    logic        err;
    logic        tieReadyLow;

    int testsRun;
    int failCount;

    mul_ctrl_if mulBus ();

    mul_ctrl #(
        .CACHE_EN   (1'b1),
        .WAIT_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .req_valid_i  (reqValid),
        .req_op_i     (reqOp),
        .src1_i       (src1),
        .src2_i       (src2),
        .ex_allowin_i (exAllowin),
        .stall_o      (stall),
        .res_valid_o  (resValid),
        .res_o        (res),
        .err_o        (err),
        .mul          (mulBus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: samples start, returns the product with ready one cycle later.
    logic [63:0] aExt, bExt;
    assign aExt = mulBus.mul_signed_o ? {{32{mulBus.mul_op1_o[31]}}, mulBus.mul_op1_o} : {32'b0, mulBus.mul_op1_o};
    assign bExt = mulBus.mul_signed_o ? {{32{mulBus.mul_op2_o[31]}}, mulBus.mul_op2_o} : {32'b0, mulBus.mul_op2_o};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulBus.mul_ready_i  <= 1'b0;
            mulBus.mul_result_i <= '0;
        end else begin
            mulBus.mul_ready_i  <= mulBus.mul_start_o && !tieReadyLow;
            mulBus.mul_result_i <= aExt * bExt;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic allowin, input logic fl);
        reqValid  = valid;
        reqOp     = op;
        src1      = a;
        src2      = b;
        exAllowin = allowin;
        flush     = fl;
    endtask

    task automatic runMiss(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRes);
        step();
        applyStimulus(1'b1, op, a, b, 1'b1, 1'b0);
        #1;
        checkOutput("miss.stallT", stall, 1);
        checkOutput("miss.noStartT", mulBus.mul_start_o, 0);
        step();
        #1;
        checkOutput("miss.startT1", mulBus.mul_start_o, 1);
        checkOutput("miss.signedT1", mulBus.mul_signed_o, (op != 2'b10));
        checkOutput("miss.op1T1", mulBus.mul_op1_o, a);
        checkOutput("miss.flushLow", mulBus.mul_flush_o, 0);
        step();
        #1;
        checkOutput("miss.startT2", mulBus.mul_start_o, 0);
        checkOutput("miss.stallT2", stall, 1);
        checkOutput("miss.noValidT2", resValid, 0);
        step();
        reqValid = 1'b0;
        #1;
        checkOutput("miss.validT3", resValid, 1);
        checkOutput("miss.resT3", res, expRes);
        checkOutput("miss.stallT3", stall, 0);
        step();
        #1;
        checkOutput("miss.idleT4", resValid, 0);
    endtask

    task automatic runHit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRes);
        step();
        applyStimulus(1'b1, op, a, b, 1'b1, 1'b0);
        #1;
        checkOutput("hit.stallT", stall, 1);
        step();
        reqValid = 1'b0;
        #1;
        checkOutput("hit.validT1", resValid, 1);
        checkOutput("hit.resT1", res, expRes);
        checkOutput("hit.noStartT1", mulBus.mul_start_o, 0);
        step();
        #1;
        checkOutput("hit.idleT2", resValid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        testsRun    = 0;
        failCount   = 0;
        tieReadyLow = 1'b0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        checkOutput("rst.stall", stall, 0);
        checkOutput("rst.valid", resValid, 0);
        checkOutput("rst.res", res, 0);
        checkOutput("rst.start", mulBus.mul_start_o, 0);
        checkOutput("rst.err", err, 0);
        checkOutput("rst.op1", mulBus.mul_op1_o, 0);
        rst_n = 1'b1;

        // Miss, signed-high hit, then unsigned-high miss on the same operands
        runMiss(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        runHit (2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        runMiss(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);

        // Backpressure: four DONE cycles with ex_allowin low
        step();
        applyStimulus(1'b1, 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
        step();
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp.valid", resValid, 1);
            checkOutput("bp.res", res, 32'h0000_000F);
            checkOutput("bp.noStart", mulBus.mul_start_o, 0);
            step();
        end
        applyStimulus(1'b0, 2'b00, 32'd3, 32'd5, 1'b1, 1'b0);
        #1;
        checkOutput("bp.releaseValid", resValid, 1);
        step();
        #1;
        checkOutput("bp.idleValid", resValid, 0);
        checkOutput("bp.idleStall", stall, 0);

        // Flush in the same cycle the multiplier returns ready
        step();
        applyStimulus(1'b1, 2'b01, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0);
        step();
        step();
        flush    = 1'b1;
        reqValid = 1'b0;
        #1;
        checkOutput("flush.mulFlush", mulBus.mul_flush_o, 1);
        step();
        flush = 1'b0;
        #1;
        checkOutput("flush.noValid", resValid, 0);
        checkOutput("flush.noStall", stall, 0);
        step();
        #1;
        checkOutput("flush.stillIdle", resValid, 0);
        runHit(2'b00, 32'd3, 32'd5, 32'h0000_000F);

        // Async reset during WAIT invalidates the cache
        runHit(2'b01, 32'd3, 32'd5, 32'h0000_0000);
        step();
        applyStimulus(1'b1, 2'b10, 32'd3, 32'd5, 1'b1, 1'b0);
        step();
        step();
        #1;
        checkOutput("arst.stallInWait", stall, 1);
        rst_n    = 1'b0;
        reqValid = 1'b0;
        #1;
        checkOutput("arst.stall", stall, 0);
        checkOutput("arst.valid", resValid, 0);
        checkOutput("arst.res", res, 0);
        checkOutput("arst.start", mulBus.mul_start_o, 0);
        checkOutput("arst.op1", mulBus.mul_op1_o, 0);
        checkOutput("arst.op2", mulBus.mul_op2_o, 0);
        checkOutput("arst.signed", mulBus.mul_signed_o, 0);
        step();
        rst_n = 1'b1;
        runMiss(2'b00, 32'd3, 32'd5, 32'h0000_000F);

        // Watchdog: ready never arrives
        tieReadyLow = 1'b1;
        step();
        applyStimulus(1'b1, 2'b00, 32'h10, 32'h10, 1'b1, 1'b0);
        step();
        #1;
        checkOutput("wd.start", mulBus.mul_start_o, 1);
        step();
        #1;
        checkOutput("wd.errWait0", err, 0);
        step();
        step();
        step();
        reqValid = 1'b0;
        #1;
        checkOutput("wd.stallWait3", stall, 1);
        checkOutput("wd.errWait3", err, 0);
        step();
        #1;
        checkOutput("wd.errSet", err, 1);
        checkOutput("wd.idleStall", stall, 0);
        checkOutput("wd.noValid", resValid, 0);
        tieReadyLow = 1'b0;
        runHit(2'b00, 32'd3, 32'd5, 32'h0000_000F);
        runMiss(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runHit(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("wd.errSticky", err, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
